ram_init_sequencer: RTL and testbench

Write-side front end that sits directly upstream of `RAM_CONFIGURABLE`. It owns the RAM's contents after reset and on re-initialisation requests. It walks every entry writing the reset value, either zero or a sequential value, using all write ports in parallel, and holds `ramReady_o` low meanwhile. Once initialisation is done it forwards core write traffic unchanged to the RAM's `wrEn_i`/`addrWr_i`/`dataWr_i`.

---
 rtl/ram_init_pkg.sv | 27 ++
 rtl/ram_init_sequencer.sv | 99 +++++++++
 tb/tb_ram_init_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ram_init_pkg.sv
// Shared definitions for the RAM initialisation sequencer.
// Holds the sequencer state type and the helper that produces
// the value written into each entry during an init walk.

`ifndef RAM_RESET_ZERO
`define RAM_RESET_ZERO 0
`endif
`ifndef RAM_RESET_SEQ
`define RAM_RESET_SEQ 1
`endif

package ram_init_pkg;

  typedef enum logic {INIT, READY} ramInitState_t;

  // Value written into entry idx: zero, or seqStart+idx in sequential mode.
  // The caller truncates the result to its data width.
  function automatic logic [31:0] initData(input int resetVal,
                                           input int seqStart,
                                           input int idx);
    if (resetVal == `RAM_RESET_SEQ) begin
      return 32'(seqStart + idx);
    end
    return 32'd0;
  endfunction

endpackage

// File: rtl/ram_init_sequencer.sv
// Write-side front end for the configurable RAM.
// After reset, or on an init request, it walks every entry writing the
// reset value through all write ports at once and keeps ramReady_o low.
// Once the walk ends, core writes are passed straight through to the RAM.

module ram_init_sequencer
  import ram_init_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int INDEX        = 4,
  parameter int WIDTH        = 8,
  parameter int NUM_WR_PORTS = 4,
  parameter int RESET_VAL    = `RAM_RESET_ZERO,
  parameter int SEQ_START    = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                initReq_i,
  input  logic [NUM_WR_PORTS-1:0]             coreWrEn_i,
  input  logic [NUM_WR_PORTS-1:0][INDEX-1:0]  coreAddrWr_i,
  input  logic [NUM_WR_PORTS-1:0][WIDTH-1:0]  coreDataWr_i,
  output logic [NUM_WR_PORTS-1:0]             wrEn_o,
  output logic [NUM_WR_PORTS-1:0][INDEX-1:0]  addrWr_o,
  output logic [NUM_WR_PORTS-1:0][WIDTH-1:0]  dataWr_o,
  output logic                                ramReady_o,
  output logic                                wrDropErr_o
);

  ramInitState_t state, stateNext;
  logic [INDEX:0] ptr, ptrNext;
  logic           dropErr;
  logic           dropNow;
  logic           lastBeat;

  // The current beat is the last one once it reaches or passes the final entry.
  assign lastBeat    = (32'(ptr) + 32'(NUM_WR_PORTS)) >= 32'(DEPTH);
  assign wrDropErr_o = dropErr;

  // State, walk pointer and the sticky dropped-write flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= INIT;
      ptr     <= '0;
      dropErr <= 1'b0;
    end else begin
      state <= stateNext;
      ptr   <= ptrNext;
      if (dropNow) begin
        dropErr <= 1'b1;
      end
    end
  end

  // Next-state logic plus the RAM write port drive; everything is quiet in reset.
  always_comb begin
    stateNext  = state;
    ptrNext    = ptr;
    wrEn_o     = '0;
    addrWr_o   = '0;
    dataWr_o   = '0;
    ramReady_o = 1'b0;
    dropNow    = 1'b0;
    if (!reset) begin
      case (state)
        INIT: begin
          for (int k = 0; k < NUM_WR_PORTS; k++) begin
            wrEn_o[k]   = (32'(ptr) + 32'(k)) < 32'(DEPTH);
            addrWr_o[k] = INDEX'(32'(ptr) + 32'(k));
            dataWr_o[k] = WIDTH'(initData(RESET_VAL, SEQ_START, int'(ptr) + k));
          end
          dropNow = |coreWrEn_i;
          if (initReq_i) begin
            ptrNext = '0;
          end else if (lastBeat) begin
            stateNext = READY;
            ptrNext   = '0;
          end else begin
            ptrNext = ptr + (INDEX+1)'(NUM_WR_PORTS);
          end
        end
        READY: begin
          wrEn_o     = coreWrEn_i;
          addrWr_o   = coreAddrWr_i;
          dataWr_o   = coreDataWr_i;
          ramReady_o = 1'b1;
          if (initReq_i) begin
            stateNext = INIT;
            ptrNext   = '0;
          end
        end
        default: begin
          stateNext = INIT;
          ptrNext   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_init_sequencer.sv
// Self-checking bench for ram_init_sequencer.
// Two instances share the stimulus: a 16-entry zero-fill RAM and a
// 10-entry sequential-fill RAM (base 32), which exercises a partial last beat.
// The reference model tracks how many beats of the current walk have been
// issued and derives the expected write ports from that.

`ifndef RAM_RESET_ZERO
`define RAM_RESET_ZERO 0
`endif
`ifndef RAM_RESET_SEQ
`define RAM_RESET_SEQ 1
`endif

module tb_ram_init_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic initReq;
  logic [3:0]      coreEn;
  logic [3:0][3:0] coreAddr;
  logic [3:0][7:0] coreData;

  logic [3:0]      wrEnA, wrEnB;
  logic [3:0][3:0] addrA, addrB;
  logic [3:0][7:0] dataA, dataB;
  logic            readyA, readyB, errA, errB;

  int vectors = 0;
  int miscompares = 0;

  // Model state: beats issued in the current walk, and sticky error flag.
  int beatA, beatB;
  bit modelErrA, modelErrB;

  always #5 clk = ~clk;

  ram_init_sequencer #(
    .DEPTH(16), .INDEX(4), .WIDTH(8), .NUM_WR_PORTS(4),
    .RESET_VAL(`RAM_RESET_ZERO), .SEQ_START(0)
  ) dutA (
    .clk(clk), .reset(reset), .initReq_i(initReq),
    .coreWrEn_i(coreEn), .coreAddrWr_i(coreAddr), .coreDataWr_i(coreData),
    .wrEn_o(wrEnA), .addrWr_o(addrA), .dataWr_o(dataA),
    .ramReady_o(readyA), .wrDropErr_o(errA)
  );

  ram_init_sequencer #(
    .DEPTH(10), .INDEX(4), .WIDTH(8), .NUM_WR_PORTS(4),
    .RESET_VAL(`RAM_RESET_SEQ), .SEQ_START(32)
  ) dutB (
    .clk(clk), .reset(reset), .initReq_i(initReq),
    .coreWrEn_i(coreEn), .coreAddrWr_i(coreAddr), .coreDataWr_i(coreData),
    .wrEn_o(wrEnB), .addrWr_o(addrB), .dataWr_o(dataB),
    .ramReady_o(readyB), .wrDropErr_o(errB)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected RAM-side outputs for a RAM of the given depth, B = ceil(depth/4) beats.
  task automatic expectOut(input int depth, input bit seq, input int seqStart, input int beat,
                           output logic [3:0] en, output logic [15:0] ad,
                           output logic [31:0] da, output logic rdy);
    int nBeats;
    int entry;
    nBeats = (depth + 3) / 4;
    en = '0; ad = '0; da = '0; rdy = 1'b0;
    if (!reset) begin
      if (beat < nBeats) begin
        for (int k = 0; k < 4; k++) begin
          entry = beat * 4 + k;
          en[k] = (entry < depth);
          ad[k*4 +: 4] = 4'(entry);
          da[k*8 +: 8] = seq ? 8'(seqStart + entry) : 8'h00;
        end
      end else begin
        en  = coreEn;
        ad  = coreAddr;
        da  = coreData;
        rdy = 1'b1;
      end
    end
  endtask

  // Advance one RAM's model across a clock edge.
  task automatic stepModel(input int depth, inout int beat, inout bit err);
    int nBeats;
    nBeats = (depth + 3) / 4;
    if (reset) begin
      beat = 0;
      err  = 1'b0;
    end else if (beat < nBeats) begin
      if (|coreEn) err = 1'b1;
      beat = initReq ? 0 : beat + 1;
    end else if (initReq) begin
      beat = 0;
    end
  endtask

  // Drive one cycle of inputs, check at the falling edge, then step the model.
  task automatic applyStimulus(input logic rst, input logic req, input logic [3:0] en,
                               input logic [15:0] ad, input logic [31:0] da);
    logic [3:0] eEn;
    logic [15:0] eAd;
    logic [31:0] eDa;
    logic eRdy;
    reset = rst; initReq = req; coreEn = en; coreAddr = ad; coreData = da;
    @(negedge clk);
    expectOut(16, 1'b0, 0, beatA, eEn, eAd, eDa, eRdy);
    checkOutput("A.wrEn", 64'(wrEnA), 64'(eEn));
    checkOutput("A.addr", 64'(addrA), 64'(eAd));
    checkOutput("A.data", 64'(dataA), 64'(eDa));
    checkOutput("A.ready", 64'(readyA), 64'(eRdy));
    checkOutput("A.dropErr", 64'(errA), 64'(modelErrA));
    expectOut(10, 1'b1, 32, beatB, eEn, eAd, eDa, eRdy);
    checkOutput("B.wrEn", 64'(wrEnB), 64'(eEn));
    checkOutput("B.addr", 64'(addrB), 64'(eAd));
    checkOutput("B.data", 64'(dataB), 64'(eDa));
    checkOutput("B.ready", 64'(readyB), 64'(eRdy));
    checkOutput("B.dropErr", 64'(errB), 64'(modelErrB));
    @(posedge clk);
    stepModel(16, beatA, modelErrA);
    stepModel(10, beatB, modelErrB);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
  endtask

  initial begin
    logic [3:0] rEn;
    logic [15:0] rAd;
    logic [31:0] rDa;
    beatA = 0; beatB = 0; modelErrA = 1'b0; modelErrB = 1'b0;
    reset = 1'b1; initReq = 1'b0; coreEn = '0; coreAddr = '0; coreData = '0;
    @(posedge clk); #1;

    // Reset held, then a full walk after release.
    applyStimulus(1'b1, 1'b0, 4'h0, 16'h0, 32'h0);
    idle(6);

    // Core write on port 2 (addr 5, data 0xAA) passes through in the same cycle.
    applyStimulus(1'b0, 1'b0, 4'b0100, 16'h0500, 32'h00AA_0000);

    // Random traffic while ready.
    for (int i = 0; i < 20; i++) begin
      rEn = 4'($urandom); rAd = 16'($urandom); rDa = $urandom;
      applyStimulus(1'b0, 1'b0, rEn, rAd, rDa);
    end

    // Init request, then a second request during beat 2 restarts the walk.
    applyStimulus(1'b0, 1'b1, 4'h0, 16'h0, 32'h0);
    idle(2);
    applyStimulus(1'b0, 1'b1, 4'h0, 16'h0, 32'h0);
    idle(6);

    // Core write on port 0 in cycle 1 of a walk is dropped and flags the error.
    applyStimulus(1'b1, 1'b0, 4'h0, 16'h0, 32'h0);
    idle(1);
    applyStimulus(1'b0, 1'b0, 4'b0001, 16'h0007, 32'h0000_0055);
    idle(6);

    // Reset pulse in beat 2, then a full walk from address 0.
    applyStimulus(1'b1, 1'b0, 4'h0, 16'h0, 32'h0);
    idle(2);
    applyStimulus(1'b1, 1'b0, 4'h0, 16'h0, 32'h0);
    idle(6);

    // Random mix of resets, init requests and core traffic.
    for (int i = 0; i < 300; i++) begin
      rEn = 4'($urandom); rAd = 16'($urandom); rDa = $urandom;
      if (($urandom % 4) != 0) rEn = 4'h0;
      applyStimulus(($urandom % 40) == 0, ($urandom % 12) == 0, rEn, rAd, rDa);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
